// File: rtl/flit_merge_arb2.sv
// Two-requester round-robin flit merge with a one-entry registered output stage.
// Optional per-input saturating grant counters are enabled by defining GRANT_CNT_EN.
module flit_merge_arb2 #(
  parameter int W     = 9,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  input  logic [W-1:0]     in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [W-1:0]     in1_data,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] data_q, data_d;
  logic         src_q, src_d;
  logic         rr_ptr_q, rr_ptr_d;
  logic         can_load;
  logic         grant_idx;
  logic         load;

  // Grant is gated by rst_n so neither requester sees ready while reset is held.
  always_comb begin
    can_load  = (state_q == EMPTY) || out_ready;
    grant_idx = (in0_valid && in1_valid) ? rr_ptr_q : in1_valid;
    load      = rst_n && can_load && (in0_valid || in1_valid);
  end

  assign in0_ready = load && !grant_idx;
  assign in1_ready = load && grant_idx;
  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    src_d    = src_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      EMPTY: begin
        if (load) state_d = FULL;
      end
      FULL: begin
        if (out_ready && !load) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    if (load) begin
      data_d   = grant_idx ? in1_data : in0_data;
      src_d    = grant_idx;
      rr_ptr_d = ~grant_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      data_q   <= '0;
      src_q    <= 1'b0;
      rr_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      src_q    <= src_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef GRANT_CNT_EN
  logic [1:0]       xfer;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  assign xfer = {in1_valid && in1_ready, in0_valid && in0_ready};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      // Saturate at all-ones instead of wrapping.
      always_comb begin
        cnt_d[gi] = cnt_q[gi];
        if (xfer[gi] && (cnt_q[gi] != {CNT_W{1'b1}})) cnt_d[gi] = cnt_q[gi] + CNT_W'(1);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q[gi] <= '0;
        else        cnt_q[gi] <= cnt_d[gi];
      end
    end
  endgenerate

  assign grant_cnt0 = cnt_q[0];
  assign grant_cnt1 = cnt_q[1];
`else
  assign grant_cnt0 = '0;
  assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_flit_merge_arb2.sv
// Directed self-checking bench for flit_merge_arb2 (W=9, CNT_W=4).
module tb_flit_merge_arb2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in0_valid, in1_valid, out_ready;
  logic [8:0] in0_data, in1_data;
  logic       in0_ready, in1_ready, out_valid, out_src;
  logic [8:0] out_data;
  logic [3:0] grant_cnt0, grant_cnt1;

  int checks   = 0;
  int failures = 0;

  logic [8:0] d0, d1, exp_data;
  logic       exp_src;

  always #5 clk = ~clk;

  flit_merge_arb2 #(.W(9), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in0_valid  (in0_valid),
    .in0_data   (in0_data),
    .in0_ready  (in0_ready),
    .in1_valid  (in1_valid),
    .in1_data   (in1_data),
    .in1_ready  (in1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b0;
    in0_data = 9'h000; in1_data = 9'h000;

    // Reset held with requests pending: nothing may be accepted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_src", out_src, 0);
    check("rst_in0_ready", in0_ready, 0);
    check("rst_in1_ready", in1_ready, 0);
    check("rst_cnt0", grant_cnt0, 0);
    check("rst_cnt1", grant_cnt1, 0);

    // Release; in0 alone sends 0x045.
    tick();
    rst_n = 1'b1; in1_valid = 1'b0; in0_valid = 1'b1; in0_data = 9'h045; out_ready = 1'b1;
    @(negedge clk);
    check("single_in0_ready", in0_ready, 1);
    check("single_in1_ready", in1_ready, 0);
    check("single_pre_valid", out_valid, 0);
    tick();
    in0_valid = 1'b0;
    @(negedge clk);
    check("single_out_valid", out_valid, 1);
    check("single_out_data", out_data, 9'h045);
    check("single_out_src", out_src, 0);
    check("idle_in0_ready", in0_ready, 0);

    // in1 alone, which also returns the pointer to in0.
    tick();
    in1_valid = 1'b1; in1_data = 9'h0B7;
    @(negedge clk);
    check("in1only_in1_ready", in1_ready, 1);
    check("in1only_in0_ready", in0_ready, 0);
    tick();
    in1_valid = 1'b0;
    check("in1only_out_data", out_data, 9'h0B7);
    check("in1only_out_src", out_src, 1);

    // Both valid each cycle: grants alternate in0,in1,in0,in1.
    d0 = 9'h101; d1 = 9'h082;
    for (int k = 0; k < 4; k++) begin
      in0_valid = 1'b1; in1_valid = 1'b1; in0_data = d0; in1_data = d1;
      exp_src  = (k % 2 == 1);
      exp_data = exp_src ? d1 : d0;
      @(negedge clk);
      check($sformatf("rr%0d_in0_ready", k), in0_ready, !exp_src);
      check($sformatf("rr%0d_in1_ready", k), in1_ready, exp_src);
      tick();
      check($sformatf("rr%0d_out_valid", k), out_valid, 1);
      check($sformatf("rr%0d_out_data", k), out_data, exp_data);
      check($sformatf("rr%0d_out_src", k), out_src, exp_src);
      if (exp_src) d1 = d1 + 9'd2;
      else         d0 = d0 + 9'd2;
    end
    in0_valid = 1'b0; in1_valid = 1'b0;

    // Backpressure on a buffered 0x1A3 from in0.
    in0_valid = 1'b1; in0_data = 9'h1A3;
    @(negedge clk);
    check("bp_load_in0_ready", in0_ready, 1);
    tick();
    out_ready = 1'b0; in0_data = 9'h0AA; in1_valid = 1'b1; in1_data = 9'h155;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("bp%0d_out_valid", k), out_valid, 1);
      check($sformatf("bp%0d_out_data", k), out_data, 9'h1A3);
      check($sformatf("bp%0d_out_src", k), out_src, 0);
      check($sformatf("bp%0d_in0_ready", k), in0_ready, 0);
      check($sformatf("bp%0d_in1_ready", k), in1_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_resume_in1_ready", in1_ready, 1);
    check("bp_resume_in0_ready", in0_ready, 0);
    tick();
    check("bp_resume_out_data", out_data, 9'h155);
    check("bp_resume_out_src", out_src, 1);
    in1_valid = 1'b0;
    @(negedge clk);
    check("bp_next_in0_ready", in0_ready, 1);
    tick();
    check("bp_next_out_data", out_data, 9'h0AA);
    check("bp_next_out_src", out_src, 0);
    in0_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("full_before_rst", out_valid, 1);

    // Asynchronous reset while FULL; pointer was on in1, must come back on in0.
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    in0_valid = 1'b1; in1_valid = 1'b1; in0_data = 9'h011; in1_data = 9'h122; out_ready = 1'b1;
    #1;
    check("arst_in0_ready", in0_ready, 0);
    check("arst_in1_ready", in1_ready, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in0_ready", in0_ready, 1);
    check("post_rst_in1_ready", in1_ready, 0);
    tick();
    check("post_rst_out_src", out_src, 0);
    check("post_rst_out_data", out_data, 9'h011);
    in0_valid = 1'b0; in1_valid = 1'b0;

    // Grant counters: 20 consecutive in0 flits from a fresh reset.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; in0_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in0_data = 9'(k);
      tick();
    end
`ifdef GRANT_CNT_EN
    check("cnt0_after5", grant_cnt0, 5);
`else
    check("cnt0_after5", grant_cnt0, 0);
`endif
    for (int k = 5; k < 20; k++) begin
      in0_data = 9'(k);
      tick();
    end
`ifdef GRANT_CNT_EN
    check("cnt0_after20", grant_cnt0, 15);
`else
    check("cnt0_after20", grant_cnt0, 0);
`endif
    check("cnt1_after20", grant_cnt1, 0);
    check("cnt_last_out_data", out_data, 9'd19);
    in0_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
